// File: rtl/parametros_hacia_rtc.sv
// Write path toward the RTC: snapshots the user-edited clock, date and timer
// values, validates them as BCD, then writes them one register at a time to
// the RTC bus controller and finishes with a single transfer command.
module parametros_hacia_rtc #(
    parameter logic [7:0]  ADDR_S   = 8'h21,
    parameter logic [7:0]  ADDR_D   = 8'h24,
    parameter logic [7:0]  ADDR_ST  = 8'h41,
    parameter logic [7:0]  CMD_ADDR = 8'hF1,
    parameter logic [7:0]  CMD_DATA = 8'hF1,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] sel,
    input  logic [7:0] s,
    input  logic [7:0] m,
    input  logic [7:0] h,
    input  logic [7:0] d,
    input  logic [7:0] me,
    input  logic [7:0] a,
    input  logic [7:0] st,
    input  logic [7:0] mt,
    input  logic [7:0] ht,
    input  logic       wr_done,
    output logic       wr_req,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        StIdle, StCheck, StIssue, StWait, StNext, StCommit, StCwait, StFin
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q;
    logic [7:0]    snap_q [9];   // 0..2 time, 3..5 date, 6..8 timer
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          capture;
    logic [3:0]    first_idx, last_idx;
    logic          ok_time, ok_date, ok_timer, group_ok;

    // Both nibbles decimal and value inside [lo, hi]; BCD order matches hex order.
    function automatic logic bcd_in(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    // Map a flat register index onto its RTC address.
    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = ADDR_S;
            4'd1:    r = ADDR_S + 8'd1;
            4'd2:    r = ADDR_S + 8'd2;
            4'd3:    r = ADDR_D;
            4'd4:    r = ADDR_D + 8'd1;
            4'd5:    r = ADDR_D + 8'd2;
            4'd6:    r = ADDR_ST;
            4'd7:    r = ADDR_ST + 8'd1;
            default: r = ADDR_ST + 8'd2;
        endcase
        return r;
    endfunction

    // Validation of each group against the captured snapshot.
    always_comb begin
        ok_time  = bcd_in(snap_q[0], 8'h00, 8'h59) && bcd_in(snap_q[1], 8'h00, 8'h59) &&
                   bcd_in(snap_q[2], 8'h00, 8'h23);
        ok_date  = bcd_in(snap_q[3], 8'h01, 8'h31) && bcd_in(snap_q[4], 8'h01, 8'h12) &&
                   bcd_in(snap_q[5], 8'h00, 8'h99);
        ok_timer = bcd_in(snap_q[6], 8'h00, 8'h59) && bcd_in(snap_q[7], 8'h00, 8'h59) &&
                   bcd_in(snap_q[8], 8'h00, 8'h23);
        unique case (sel_q)
            2'b00: begin group_ok = ok_time;  first_idx = 4'd0; last_idx = 4'd2; end
            2'b01: begin group_ok = ok_date;  first_idx = 4'd3; last_idx = 4'd5; end
            2'b10: begin group_ok = ok_timer; first_idx = 4'd6; last_idx = 4'd8; end
            default: begin
                group_ok  = ok_time && ok_date && ok_timer;
                first_idx = 4'd0;
                last_idx  = 4'd8;
            end
        endcase
    end

    // Next-state logic; the bus address/data are loaded on entry to ISSUE/COMMIT.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    capture = 1'b1;
                    err_d   = 1'b0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!group_ok) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    idx_d   = first_idx;
                    addr_d  = reg_addr(first_idx);
                    data_d  = snap_q[first_idx];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait, StCwait: begin
                // wr_done takes priority over an expiring timeout
                if (wr_done) begin
                    state_d = (state_q == StWait) ? StNext : StFin;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StNext: begin
                if (idx_q == last_idx) begin
                    addr_d  = CMD_ADDR;
                    data_d  = CMD_DATA;
                    state_d = StCommit;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    addr_d  = reg_addr(idx_q + 4'd1);
                    data_d  = snap_q[idx_q + 4'd1];
                    state_d = StIssue;
                end
            end
            StCommit: begin
                cnt_d   = '0;
                state_d = StCwait;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Snapshot of sel and all nine values, taken only on an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= 2'b00;
            for (int i = 0; i < 9; i++) snap_q[i] <= 8'h00;
        end else if (capture) begin
            sel_q     <= sel;
            snap_q[0] <= s;
            snap_q[1] <= m;
            snap_q[2] <= h;
            snap_q[3] <= d;
            snap_q[4] <= me;
            snap_q[5] <= a;
            snap_q[6] <= st;
            snap_q[7] <= mt;
            snap_q[8] <= ht;
        end
    end

    // Outputs decoded from state so reset clears them immediately.
    always_comb begin
        wr_req  = (state_q == StIssue) || (state_q == StCommit);
        busy    = (state_q != StIdle);
        done    = (state_q == StFin);
        err     = err_q;
        wr_addr = addr_q;
        wr_data = data_q;
    end

endmodule

// File: tb/tb_parametros_hacia_rtc.sv
// Scoreboard bench: each accepted start pushes the expected bus events derived
// from a decimal-range model; a monitor pops and compares as the DUT acts.
module tb_parametros_hacia_rtc;

    localparam int TIMEOUT = 1023;
    localparam int EV_WR = 0, EV_DONE = 1, EV_ERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] data;
        bit         to;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [7:0] s = 0, m = 0, h = 0, d = 0, me = 0, a = 0, st = 0, mt = 0, ht = 0;
    logic       wr_done = 1'b0;
    logic       wr_req, busy, done, err;
    logic [7:0] wr_addr, wr_data;

    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];
    int resp_delay = 1;      // 0 = never answer
    int n_req = 0;
    int cyc = 0;
    int last_req_cyc = 0;
    bit pending = 0;
    logic [7:0] cur_addr, cur_data;
    logic err_prev = 0, done_prev = 0;

    logic [7:0] addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    int lo_tab [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    int hi_tab [9] = '{59, 59, 23, 31, 12, 99, 59, 59, 23};

    parametros_hacia_rtc dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel),
        .s(s), .m(m), .h(h), .d(d), .me(me), .a(a), .st(st), .mt(mt), .ht(ht),
        .wr_done(wr_done), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] ad, input logic [7:0] da);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected none",
                     kind, ad, da);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == EV_WR && e.kind == EV_WR) begin
                chk("wr_addr", ad, e.addr);
                chk("wr_data", da, e.data);
            end
            if (kind == EV_ERR && e.kind == EV_ERR && e.to)
                chk("timeout_cycles", cyc - last_req_cyc, TIMEOUT + 2);
        end
    endtask

    // Monitor: compares every bus event against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            pending = 0;
        end else begin
            if (wr_req) begin
                n_req++;
                last_req_cyc = cyc;
                cur_addr = wr_addr;
                cur_data = wr_data;
                pending = 1;
                expect_ev(EV_WR, wr_addr, wr_data);
            end
            if (wr_done && pending) begin
                chk("stable_addr", wr_addr, cur_addr);
                chk("stable_data", wr_data, cur_data);
                pending = 0;
            end
            if (done) begin
                expect_ev(EV_DONE, 8'h00, 8'h00);
                chk("busy_with_done", busy, 1);
            end
            if (err && !err_prev) expect_ev(EV_ERR, 8'h00, 8'h00);
            if (done_prev) chk("busy_after_done", busy, 0);
        end
        err_prev = err;
        done_prev = done;
    end

    // Bus controller responder.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && wr_req && resp_delay > 0) begin
                repeat (resp_delay) @(posedge clk);
                #1 wr_done = 1'b1;
                @(posedge clk);
                #1 wr_done = 1'b0;
            end
        end
    end

    task automatic drive_vals(input logic [1:0] sl, input logic [71:0] pv);
        sel = sl;
        s  = pv[7:0];   m  = pv[15:8];  h  = pv[23:16];
        d  = pv[31:24]; me = pv[39:32]; a  = pv[47:40];
        st = pv[55:48]; mt = pv[63:56]; ht = pv[71:64];
    endtask

    function automatic bit field_ok(input int idx, input logic [7:0] v);
        int tens = v / 16;
        int ones = v % 16;
        if (tens > 9 || ones > 9) return 0;
        return (tens * 10 + ones >= lo_tab[idx]) && (tens * 10 + ones <= hi_tab[idx]);
    endfunction

    // Reference model: push the expected bus events, return expected final err.
    task automatic start_txn(input logic [1:0] sl, input logic [71:0] pv, input int dly,
                             output bit exp_err);
        int lo, hi;
        bit ok = 1;
        ev_t e;
        lo = (sl == 2'b01) ? 3 : (sl == 2'b10) ? 6 : 0;
        hi = (sl == 2'b00) ? 2 : (sl == 2'b01) ? 5 : 8;
        for (int i = lo; i <= hi; i++) if (!field_ok(i, pv[8*i +: 8])) ok = 0;
        exp_err = 0;
        if (!ok) begin
            e = '{EV_ERR, 8'h00, 8'h00, 1'b0};
            exp_q.push_back(e);
            exp_err = 1;
        end else if (dly == 0) begin
            e = '{EV_WR, addr_tab[lo], pv[8*lo +: 8], 1'b0};
            exp_q.push_back(e);
            e = '{EV_ERR, 8'h00, 8'h00, 1'b1};
            exp_q.push_back(e);
            exp_err = 1;
        end else begin
            for (int i = lo; i <= hi; i++) begin
                e = '{EV_WR, addr_tab[i], pv[8*i +: 8], 1'b0};
                exp_q.push_back(e);
            end
            e = '{EV_WR, 8'hF1, 8'hF1, 1'b0};
            exp_q.push_back(e);
            e = '{EV_DONE, 8'h00, 8'h00, 1'b0};
            exp_q.push_back(e);
        end
        resp_delay = dly;
        @(posedge clk);
        #1;
        drive_vals(sl, pv);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input bit exp_err);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_bound", (n < 3000), 1);
        @(negedge clk);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("err_final", err, exp_err);
        chk("busy_final", busy, 0);
    endtask

    function automatic logic [7:0] rand_bcd(input int lo, input int hi);
        int x;
        if ($urandom_range(7, 0) == 0) return 8'($urandom_range(255, 0));
        x = $urandom_range(hi, lo);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    initial begin
        bit ee;
        int nr;
        logic [71:0] pv;

        // Reset state
        #1;
        chk("rst_wr_req", wr_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Time group, two-cycle responder
        start_txn(2'b00, {48'h0, 8'h12, 8'h30, 8'h45}, 2, ee);
        wait_idle(ee);

        // All groups
        start_txn(2'b11, {8'h23, 8'h59, 8'h59, 8'h16, 8'h12, 8'h31, 8'h12, 8'h30, 8'h45}, 1, ee);
        wait_idle(ee);

        // Invalid month, then a valid start clears err
        start_txn(2'b01, {24'h0, 8'h16, 8'h13, 8'h05, 24'h0}, 1, ee);
        wait_idle(ee);
        start_txn(2'b01, {24'h0, 8'h99, 8'h01, 8'h01, 24'h0}, 3, ee);
        wait_idle(ee);

        // Timer group with no response: timeout on the first write
        start_txn(2'b10, {8'h01, 8'h02, 8'h03, 48'h0}, 0, ee);
        wait_idle(ee);

        // Start while busy with changed inputs is ignored
        start_txn(2'b00, {48'h0, 8'h08, 8'h07, 8'h06}, 2, ee);
        repeat (3) @(posedge clk);
        #1;
        drive_vals(2'b11, {9{8'h11}});
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(ee);

        // Reset during WAIT of the second write
        start_txn(2'b00, {48'h0, 8'h21, 8'h22, 8'h23}, 2, ee);
        nr = n_req + 2;
        for (int i = 0; i < 100 && n_req < nr; i++) @(negedge clk);
        chk("reached_second_write", n_req, nr);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst_wr_req", wr_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_wr_data", wr_data, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_req_after_reset", n_req, nr);
        chk("idle_after_reset", busy, 0);

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            pv = '0;
            for (int i = 0; i < 9; i++) pv[8*i +: 8] = rand_bcd(lo_tab[i], hi_tab[i]);
            start_txn(2'($urandom_range(3, 0)), pv, $urandom_range(4, 1), ee);
            wait_idle(ee);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
